// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and sizing for the pipeline hazard/stall controller.
// Holds the FSM state encoding, the default memory timeout and the counter widths.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALTED   = 2'b10
  } state_t;

  localparam int MEM_TIMEOUT_DEFAULT = 64;
  localparam int CNT_W               = 16;
  localparam int WAIT_W              = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; one-cycle update latency.
// No flow control: the count holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: zero-latency stall/flush decode, registered FSM and counters.
// A data-memory stall freezes the whole front end; a long enough stall halts the core until reset.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read_en,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_dbg
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall;
  logic              load_use;

  assign mem_stall = mem_req & ~mem_ready;

  assign load_use = ex_mem_read_en && (ex_rd_addr != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                     (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

  // A redirect seen during a memory stall is simply deferred: EX is frozen,
  // so ex_redirect stays asserted and wins once mem_stall drops.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    exmem_stall  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (rst) begin
      pc_stall = 1'b0;
    end else if (state == ST_HALTED || mem_stall) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_stall  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_MEM_WAIT: begin
          if (!mem_stall) begin
            state <= ST_RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= ST_HALTED;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end else begin
            state <= ST_RUN;
          end
        end
      endcase
    end
  end

  assign halted    = (state == ST_HALTED);
  assign state_dbg = state;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (pc_stall),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (ifid_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with MEM_TIMEOUT=4: hazards, memory stall, timeout halt,
// counter saturation and reset recovery, all against hand-computed values.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read_en, ex_redirect;
  logic        mem_req, mem_ready;
  logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic        ifid_flush, idex_flush, memwb_bubble, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_rd_addr     (ex_rd_addr),
    .ex_mem_read_en (ex_mem_read_en),
    .ex_redirect    (ex_redirect),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .idex_stall     (idex_stall),
    .exmem_stall    (exmem_stall),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .memwb_bubble   (memwb_bubble),
    .halted         (halted),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .state_dbg      (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read_en = 1'b0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    // Outputs stay quiet under reset even with hazards present
    mem_req = 1'b1; ex_redirect = 1'b1;
    #1;
    chk("rst_pc_stall", pc_stall, 0);
    chk("rst_ifid_flush", ifid_flush, 0);
    chk("rst_bubble", memwb_bubble, 0);
    step();
    step();
    chk("rst_state", state_dbg, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_halted", halted, 0);
    idle_inputs();
    rst = 1'b0;
    #1;

    // Load-use on rs1: one bubble
    ex_mem_read_en = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
    #1;
    chk("lu_pc_stall", pc_stall, 1);
    chk("lu_ifid_stall", ifid_stall, 1);
    chk("lu_idex_flush", idex_flush, 1);
    chk("lu_idex_stall", idex_stall, 0);
    chk("lu_ifid_flush", ifid_flush, 0);
    step();
    chk("lu_stall_cnt", stall_cnt, 1);
    ex_mem_read_en = 1'b0;
    #1;
    chk("lu_release", pc_stall, 0);

    // x0 destination never creates a hazard
    ex_mem_read_en = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0;
    #1;
    chk("x0_pc_stall", pc_stall, 0);
    chk("x0_idex_flush", idex_flush, 0);
    step();
    chk("x0_stall_cnt", stall_cnt, 1);

    // rs2 match counts; match on an unused operand does not
    ex_rd_addr = 5'd7; id_rs1_addr = 5'd3; id_rs2_addr = 5'd7;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b1;
    #1;
    chk("rs2_pc_stall", pc_stall, 1);
    id_uses_rs2 = 1'b0; id_rs1_addr = 5'd7;
    #1;
    chk("unused_pc_stall", pc_stall, 0);

    // Redirect beats load-use
    idle_inputs();
    ex_mem_read_en = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
    ex_redirect = 1'b1;
    #1;
    chk("rd_ifid_flush", ifid_flush, 1);
    chk("rd_idex_flush", idex_flush, 1);
    chk("rd_pc_stall", pc_stall, 0);
    chk("rd_ifid_stall", ifid_stall, 0);
    step();
    chk("rd_flush_cnt", flush_cnt, 1);
    chk("rd_stall_cnt", stall_cnt, 1);

    // Memory stall for 3 cycles then ready
    idle_inputs();
    mem_req = 1'b1;
    #1;
    chk("ms_state0", state_dbg, 0);
    chk("ms_pc_stall", pc_stall, 1);
    chk("ms_exmem_stall", exmem_stall, 1);
    chk("ms_bubble", memwb_bubble, 1);
    step();
    chk("ms_state1", state_dbg, 1);
    chk("ms_pc_stall_wait", pc_stall, 1);
    step();
    step();
    mem_ready = 1'b1;
    #1;
    chk("ms_release_stall", pc_stall, 0);
    step();
    chk("ms_state_back", state_dbg, 0);
    chk("ms_stall_cnt", stall_cnt, 4);

    // Redirect held during a 2-cycle memory stall
    idle_inputs();
    mem_req = 1'b1; ex_redirect = 1'b1;
    #1;
    chk("hold_flush_c0", ifid_flush, 0);
    step();
    chk("hold_flush_c1", idex_flush, 0);
    chk("hold_stall_c1", idex_stall, 1);
    step();
    mem_ready = 1'b1;
    #1;
    chk("hold_rel_ifid_flush", ifid_flush, 1);
    chk("hold_rel_idex_flush", idex_flush, 1);
    chk("hold_rel_pc_stall", pc_stall, 0);
    step();
    chk("hold_flush_cnt", flush_cnt, 2);
    chk("hold_stall_cnt", stall_cnt, 6);
    chk("hold_state", state_dbg, 0);

    // Timeout: one RUN cycle plus four MEM_WAIT cycles, then HALTED
    idle_inputs();
    mem_req = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) step();
    chk("to_state_wait", state_dbg, 1);
    chk("to_not_halted", halted, 0);
    step();
    chk("to_state_halt", state_dbg, 2);
    chk("to_halted", halted, 1);
    chk("to_stall_cnt", stall_cnt, 11);
    // HALTED ignores memory completion and redirects
    mem_ready = 1'b1; mem_req = 1'b0; ex_redirect = 1'b1;
    #1;
    chk("halt_idex_stall", idex_stall, 1);
    chk("halt_ifid_flush", ifid_flush, 0);
    chk("halt_bubble", memwb_bubble, 1);
    step();
    chk("halt_sticky", state_dbg, 2);
    chk("halt_stall_cnt", stall_cnt, 12);

    // Saturation while halted
    for (int i = 0; i < 70000; i++) step();
    chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
    step();
    chk("sat_no_wrap", stall_cnt, 16'hFFFF);
    chk("sat_flush_cnt", flush_cnt, 2);

    // Reset out of HALTED
    rst = 1'b1;
    #1;
    chk("rst2_pc_stall", pc_stall, 0);
    chk("rst2_bubble", memwb_bubble, 0);
    step();
    chk("rst2_state", state_dbg, 0);
    chk("rst2_halted", halted, 0);
    chk("rst2_stall_cnt", stall_cnt, 0);
    chk("rst2_flush_cnt", flush_cnt, 0);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("rst2_run_stall", pc_stall, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
